// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-addressed data memory with a single outstanding request.
// Sub-word stores are read-modify-write because the memory only has a whole-word write enable.
module lsu_mem_master #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // RD    | memory read of the addressed word (load or RMW first half)
    // WR    | write strobe high for exactly one cycle
    // RSP   | response held until rsp_ready
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] rd_shifted;
    logic [31:0] lane_mask;
    logic [31:0] ld_data_d;
    logic [31:0] merge_d;

    assign req_ready      = rst && (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign mem_write_en   = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

    always_comb begin
        req_err = (req_size == 2'b11)
                | ((req_size == 2'b01) && req_addr[0])
                | ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    end

    // Halfword lanes are always even, so the byte shift covers both sub-word sizes.
    always_comb begin
        shamt      = {lane_q, 3'b000};
        rd_shifted = mem_read_data >> shamt;
        lane_mask  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
        merge_d    = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
        case (size_q)
            2'b00:   ld_data_d = uns_q ? {24'h0, rd_shifted[7:0]}
                                       : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   ld_data_d = uns_q ? {16'h0, rd_shifted[15:0]}
                                       : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: ld_data_d = mem_read_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RSP;
                        end else begin
                            mem_addr_q <= {2'b00, req_addr[31:2]};
                            if (req_we && (req_size == 2'b10)) begin
                                mem_wdata_q <= req_wdata;
                                mem_we_q    <= 1'b1;
                                state_q     <= WR;
                            end else begin
                                state_q <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        mem_wdata_q <= merge_d;
                        mem_we_q    <= 1'b1;
                        state_q     <= WR;
                    end else begin
                        rsp_rdata_q <= ld_data_d;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                WR: begin
                    mem_we_q    <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small behavioural word memory.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [32];
    int n_cmp = 0;
    int n_bad = 0;

    lsu_mem_master #(.MEM_WORDS(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write_en && (mem_addr < 32)) mem[mem_addr[4:0]] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request and waits until rsp_valid; leaves the response un-acknowledged.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int nwr,
                         output logic [31:0] wa, output logic [31:0] wdat);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nwr = 0; wa = 32'hX; wdat = 32'hX;
        while (!rsp_valid && lat < 10) begin
            if (mem_write_en) begin nwr++; wa = mem_addr; wdat = mem_write_data; end
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 10) chk("rsp_timeout", 32'h0, 32'h1);
        chk("no_we_in_rsp", {31'h0, mem_write_en}, 32'h0);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
        chk("req_ready_after", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] exp);
        int lat, nwr; logic [31:0] wa, wdat;
        issue(1'b0, sz, uns, a, 32'h0, lat, nwr, wa, wdat);
        chk({tag, "_data"}, rsp_rdata, exp);
        chk({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_nwr"}, nwr, 0);
        ack();
    endtask

    task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_idx,
                         input logic [31:0] exp_word, input int exp_lat);
        int lat, nwr; logic [31:0] wa, wdat;
        issue(1'b1, sz, 1'b0, a, wd, lat, nwr, wa, wdat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_nwr"}, nwr, 1);
        chk({tag, "_widx"}, wa, exp_idx);
        chk({tag, "_wdata"}, wdat, exp_word);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
        chk({tag, "_mem"}, mem[exp_idx[4:0]], exp_word);
        ack();
    endtask

    task automatic bad(input string tag, input logic we, input logic [1:0] sz,
                       input logic [31:0] a);
        int lat, nwr; logic [31:0] wa, wdat;
        issue(we, sz, 1'b0, a, 32'hA5A5_A5A5, lat, nwr, wa, wdat);
        chk({tag, "_err"}, {31'h0, rsp_err}, 32'h1);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_nwr"}, nwr, 0);
        ack();
    endtask

    initial begin
        logic [31:0] held;
        int lat, nwr; logic [31:0] wa, wdat;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;

        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_write_en}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        store("st_word", 2'b10, 32'h10, 32'hDEAD_BEEF, 32'd4, 32'hDEAD_BEEF, 2);
        load("ld_word", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

        mem[4] = 32'h80FF_7F01;
        load("lb_s_12", 2'b00, 1'b0, 32'h12, 32'hFFFF_FFFF);
        load("lbu_13", 2'b00, 1'b1, 32'h13, 32'h0000_0080);
        load("lb_s_11", 2'b00, 1'b0, 32'h11, 32'h0000_007F);
        load("lh_s_12", 2'b01, 1'b0, 32'h12, 32'hFFFF_80FF);
        load("lhu_12", 2'b01, 1'b1, 32'h12, 32'h0000_80FF);

        mem[4] = 32'h1122_3344;
        store("sb_11", 2'b00, 32'h11, 32'h0000_005A, 32'd4, 32'h1122_5A44, 3);
        store("sh_12", 2'b01, 32'h12, 32'h1234_BEEF, 32'd4, 32'hBEEF_5A44, 3);
        chk("word3_kept", mem[3], 32'h1000_0003);
        chk("word5_kept", mem[5], 32'h1000_0005);

        bad("e_lw_12", 1'b0, 2'b10, 32'h12);
        bad("e_sh_13", 1'b1, 2'b01, 32'h13);
        bad("e_size3", 1'b0, 2'b11, 32'h10);
        bad("e_lw_80", 1'b0, 2'b10, 32'h80);
        bad("e_sw_80", 1'b1, 2'b10, 32'h80);
        chk("err_mem4_kept", mem[4], 32'hBEEF_5A44);

        // Backpressure: response must hold while a competing request is offered.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nwr, wa, wdat);
        held = rsp_rdata;
        chk("bp_data", held, 32'hBEEF_5A44);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h14;
        req_wdata = 32'h0BAD_F00D;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_hold", rsp_rdata, 32'hBEEF_5A44);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
            chk("bp_no_we", {31'h0, mem_write_en}, 32'h0);
        end
        req_valid = 1'b0;
        ack();
        chk("bp_word5_kept", mem[5], 32'h1000_0005);
        load("after_bp", 2'b00, 1'b1, 32'h13, 32'h0000_00BE);

        // Reset asserted during the WR cycle of a word store.
        chk("rw_req_ready", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h08;
        req_wdata = 32'hFACE_CAFE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rw_we_high", {31'h0, mem_write_en}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rw_we_drop", {31'h0, mem_write_en}, 32'h0);
        chk("rw_mem_addr", mem_addr, 32'h0);
        chk("rw_mem_wdata", mem_write_data, 32'h0);
        chk("rw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rw_req_ready_rst", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        chk("rw_word2_kept", mem[2], 32'h1000_0002);
        rst = 1'b1;
        #1;
        chk("rw_req_ready_rel", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        chk("rw_no_rsp", {31'h0, rsp_valid}, 32'h0);
        load("after_rst", 2'b10, 1'b0, 32'h08, 32'h1000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
